multicycle_controller: RTL and testbench

Multicycle successor to the single-cycle MIPS controller: a Moore FSM that sequences each instruction over several clocks and shares one ALU and one unified memory across fetch and data access. It sits in the multicycle datapath in place of the combinational controller. It adds a parametrised memory wait-state counter plus `bne` and `jr` support. ALU decoding is folded in.

---
 rtl/multicycle_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a multicycle MIPS datapath. One instruction is
// sequenced over several clocks, sharing a single ALU and one unified memory
// between instruction fetch and data access. Each memory access (fetch, load,
// store) is stretched to MEM_LAT cycles by a 4-bit wait counter. ALU decoding
// is folded in.
//
// Parameters
//   MEM_LAT    : cycles per memory access, 1..15
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset (0 = reset)
//   op, funct  : opcode / function field from the instruction register
//   zero       : ALU zero flag (used only in BEQ / BNE)
//   iord       : memory address source (0 = PC, 1 = ALUOut)
//   irwrite    : load instruction register
//   pcwrite    : unconditional PC write
//   pcen       : final PC enable (pcwrite or taken branch)
//   memwrite   : data memory write strobe
//   memtoreg   : register write data from memory data register
//   regdst     : destination register (1 = rd, 0 = rt)
//   regwrite   : register file write
//   alusrca    : ALU A source (0 = PC, 1 = A register)
//   alusrcb    : ALU B source (00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2)
//   pcsrc      : next-PC source (00 ALU, 01 ALUOut, 10 jump target, 11 A)
//   alucontrol : ALU operation
//   illegal    : one-cycle pulse in DECODE on an unsupported opcode/funct
//   state      : current state, for debug
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcen,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,  S_BNE    = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12, S_JR     = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    // op/funct may change after DECODE, so the load/store choice and the
    // R-type ALU operation are captured there for use in later states.
    logic       is_store_q, is_store_d;
    logic [2:0] alu_fn_q, alu_fn_d;

    logic       last_wait;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       illegal_raw;
    logic       irwrite_raw, pcwrite_raw, memwrite_raw, regwrite_raw;

    assign last_wait = (cnt_q == LAST_CNT);

    // R-type funct decode.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        alu_fn_d    = alu_fn_q;
        illegal_raw = 1'b0;
        case (state_q)
            S_FETCH:  if (last_wait) state_d = S_DECODE;
            S_DECODE: begin
                is_store_d = (op == OP_SW);
                alu_fn_d   = funct_alu;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            state_d = S_JR;
                        end else begin
                            state_d     = S_EXEC;
                            illegal_raw = ~funct_ok;
                        end
                    end
                    OP_BEQ:   state_d = S_BEQ;
                    OP_BNE:   state_d = S_BNE;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (last_wait) state_d = S_MEMWB;
            S_MEMWR:  if (last_wait) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;  // write-back/branch/jump states and codes 14-15
        endcase
        // Wait-state states never re-enter themselves from another cycle of
        // the same state, so "stay" means count and "change" means clear.
        cnt_d = (state_d == state_q) ? cnt_q + 4'd1 : 4'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            cnt_q      <= 4'd0;
            is_store_q <= 1'b0;
            alu_fn_q   <= ALU_ADD;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            alu_fn_q   <= alu_fn_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        iord         = 1'b0;
        irwrite_raw  = 1'b0;
        pcwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = 3'b000;
        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                alucontrol  = ALU_ADD;
                irwrite_raw = last_wait;
                pcwrite_raw = last_wait;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = last_wait;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = alu_fn_q;
            end
            S_ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JUMP: begin
                pcsrc       = 2'b10;
                pcwrite_raw = 1'b1;
            end
            S_JR: begin
                pcsrc       = 2'b11;
                pcwrite_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are held off for as long as reset is low, including the
    // FETCH cycle that the reset state would otherwise decode as a write.
    assign irwrite  = irwrite_raw  & reset;
    assign pcwrite  = pcwrite_raw  & reset;
    assign memwrite = memwrite_raw & reset;
    assign regwrite = regwrite_raw & reset;
    assign illegal  = illegal_raw  & reset;
    assign pcen     = (pcwrite_raw
                       | ((state_q == S_BEQ) &  zero)
                       | ((state_q == S_BNE) & ~zero)) & reset;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench: one controller with MEM_LAT=1 runs a table of
// instructions, a second with MEM_LAT=3 covers the wait-state sequence.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       o1_iord, o1_irwrite, o1_pcwrite, o1_pcen, o1_memwrite, o1_memtoreg;
    logic       o1_regdst, o1_regwrite, o1_alusrca, o1_illegal;
    logic [1:0] o1_alusrcb, o1_pcsrc;
    logic [2:0] o1_alucontrol;
    logic [3:0] o1_state;

    logic       o3_iord, o3_irwrite, o3_pcwrite, o3_pcen, o3_memwrite, o3_memtoreg;
    logic       o3_regdst, o3_regwrite, o3_alusrca, o3_illegal;
    logic [1:0] o3_alusrcb, o3_pcsrc;
    logic [2:0] o3_alucontrol;
    logic [3:0] o3_state;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(o1_iord), .irwrite(o1_irwrite), .pcwrite(o1_pcwrite), .pcen(o1_pcen),
        .memwrite(o1_memwrite), .memtoreg(o1_memtoreg), .regdst(o1_regdst),
        .regwrite(o1_regwrite), .alusrca(o1_alusrca), .alusrcb(o1_alusrcb),
        .pcsrc(o1_pcsrc), .alucontrol(o1_alucontrol), .illegal(o1_illegal),
        .state(o1_state)
    );

    multicycle_controller #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(o3_iord), .irwrite(o3_irwrite), .pcwrite(o3_pcwrite), .pcen(o3_pcen),
        .memwrite(o3_memwrite), .memtoreg(o3_memtoreg), .regdst(o3_regdst),
        .regwrite(o3_regwrite), .alusrca(o3_alusrca), .alusrcb(o3_alusrcb),
        .pcsrc(o3_pcsrc), .alucontrol(o3_alucontrol), .illegal(o3_illegal),
        .state(o3_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One instruction on the MEM_LAT=1 instance: state trace (state of cycle c
    // in nibble c), write-enable cycle counts and ALU op seen in cycle 2.
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          len;
        logic [19:0] seq;
        int          n_rw;
        int          n_mw;
        int          n_pcen;
        int          n_ill;
        logic [2:0]  alu2;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[16];
        logic [31:0] trace3, ir3, mw3, iord3;
        bit          found;

        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 20'h43210, 1, 0, 1, 0, 3'b010}; // lw
        vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 4, 20'h05210, 0, 1, 1, 0, 3'b010}; // sw
        vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 20'h07610, 1, 0, 1, 0, 3'b010}; // add
        vecs[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 20'h07610, 1, 0, 1, 0, 3'b110}; // sub
        vecs[4]  = '{6'b000000, 6'b100100, 1'b0, 4, 20'h07610, 1, 0, 1, 0, 3'b000}; // and
        vecs[5]  = '{6'b000000, 6'b100101, 1'b0, 4, 20'h07610, 1, 0, 1, 0, 3'b001}; // or
        vecs[6]  = '{6'b000000, 6'b101010, 1'b0, 4, 20'h07610, 1, 0, 1, 0, 3'b111}; // slt
        vecs[7]  = '{6'b000000, 6'b111111, 1'b0, 4, 20'h07610, 1, 0, 1, 1, 3'b010}; // bad funct
        vecs[8]  = '{6'b000100, 6'b000000, 1'b1, 3, 20'h00810, 0, 0, 2, 0, 3'b110}; // beq taken
        vecs[9]  = '{6'b000100, 6'b000000, 1'b0, 3, 20'h00810, 0, 0, 1, 0, 3'b110}; // beq not taken
        vecs[10] = '{6'b000101, 6'b000000, 1'b1, 3, 20'h00910, 0, 0, 1, 0, 3'b110}; // bne not taken
        vecs[11] = '{6'b000101, 6'b000000, 1'b0, 3, 20'h00910, 0, 0, 2, 0, 3'b110}; // bne taken
        vecs[12] = '{6'b001000, 6'b000000, 1'b0, 4, 20'h0BA10, 1, 0, 1, 0, 3'b010}; // addi
        vecs[13] = '{6'b000010, 6'b000000, 1'b0, 3, 20'h00C10, 0, 0, 2, 0, 3'b000}; // j
        vecs[14] = '{6'b000000, 6'b001000, 1'b0, 3, 20'h00D10, 0, 0, 2, 0, 3'b000}; // jr
        vecs[15] = '{6'b111111, 6'b000000, 1'b0, 2, 20'h00010, 0, 0, 1, 1, 3'b010}; // bad op

        // ---------------- reset state ----------------
        reset = 1'b0;
        op    = 6'b000000;
        funct = 6'b100000;
        zero  = 1'b0;
        #2;
        check("rst_state1", {28'd0, o1_state}, 32'd0);
        check("rst_state3", {28'd0, o3_state}, 32'd0);
        @(negedge clk);
        check("rst_wen1", {26'd0, o1_irwrite, o1_pcwrite, o1_pcen, o1_memwrite, o1_regwrite, o1_illegal}, 32'd0);
        check("rst_fetch_ctl", {27'd0, o1_alusrcb, o1_alucontrol}, {27'd0, 2'b01, 3'b010});
        check("rst_other_ctl", {24'd0, o1_iord, o1_memtoreg, o1_regdst, o1_alusrca, o1_pcsrc, 2'b00}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);

        // ---------------- instruction table (MEM_LAT=1) ----------------
        for (int v = 0; v < 16; v++) begin
            logic [19:0] tr;
            int          rw, mw, pe, il;
            logic [2:0]  a2;
            tr = '0; rw = 0; mw = 0; pe = 0; il = 0; a2 = '0;
            op    = vecs[v].op;
            funct = vecs[v].funct;
            zero  = vecs[v].zero;
            for (int c = 0; c <= vecs[v].len; c++) begin
                if (c < vecs[v].len) begin
                    tr[c*4 +: 4] = o1_state;
                    if (o1_regwrite) rw++;
                    if (o1_memwrite) mw++;
                    if (o1_pcen)     pe++;
                    if (o1_illegal)  il++;
                end else begin
                    check($sformatf("v%0d_end_state", v), {28'd0, o1_state}, 32'd0);
                end
                if (c == 2) a2 = o1_alucontrol;
                if (c < vecs[v].len) begin
                    @(posedge clk);
                    #1;
                    if (c == 1) begin
                        // op/funct are only valid during DECODE
                        op    = (vecs[v].op == 6'b101011) ? 6'b100011 : 6'b101011;
                        funct = ~vecs[v].funct;
                    end
                    @(negedge clk);
                end
            end
            check($sformatf("v%0d_trace", v),    {12'd0, tr}, {12'd0, vecs[v].seq});
            check($sformatf("v%0d_regwrite", v), rw, vecs[v].n_rw);
            check($sformatf("v%0d_memwrite", v), mw, vecs[v].n_mw);
            check($sformatf("v%0d_pcen", v),     pe, vecs[v].n_pcen);
            check($sformatf("v%0d_illegal", v),  il, vecs[v].n_ill);
            check($sformatf("v%0d_alu2", v),     {29'd0, a2}, {29'd0, vecs[v].alu2});
        end

        // ---------------- reset mid-EXEC ----------------
        op    = 6'b000000;
        funct = 6'b100000;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (o1_state == 4'd6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("exec_reached", {31'd0, found}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_state", {28'd0, o1_state}, 32'd0);
        check("async_rst_wen", {26'd0, o1_irwrite, o1_pcwrite, o1_pcen, o1_memwrite, o1_regwrite, o1_illegal}, 32'd0);
        @(negedge clk);
        check("held_rst_wen", {26'd0, o1_irwrite, o1_pcwrite, o1_pcen, o1_memwrite, o1_regwrite, o1_illegal}, 32'd0);
        check("held_rst_state", {28'd0, o1_state}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        op = 6'b101011;  // sw, for the MEM_LAT=3 sequence that follows
        funct = 6'b000000;
        @(negedge clk);
        check("post_rst_irwrite", {27'd0, o1_state, o1_irwrite}, {27'd0, 4'd0, 1'b1});

        // ---------------- sw on MEM_LAT=3 (starts in this FETCH cycle) ----------------
        trace3 = '0; ir3 = '0; mw3 = '0; iord3 = '0;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                trace3[c*4 +: 4] = o3_state;
                ir3[c]   = o3_irwrite;
                mw3[c]   = o3_memwrite;
                iord3[c] = o3_iord;
                @(posedge clk);
                #1;
                @(negedge clk);
            end else begin
                check("sw3_end_state", {28'd0, o3_state}, 32'd0);
            end
        end
        check("sw3_trace",    trace3, 32'h5552_1000);
        check("sw3_irwrite",  ir3,    32'h0000_0004);
        check("sw3_memwrite", mw3,    32'h0000_0080);
        check("sw3_iord",     iord3,  32'h0000_00E0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
